// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  // Largest value representable in the given number of decimal digits.
  function automatic int unsigned max_val(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

  localparam int unsigned MAX_VAL = max_val(4);

endpackage

// File: rtl/bin2bcd_seq_dabble_digit.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_dabble_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  always_comb begin
    d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with a held, registered result,
// optional leading-zero blanking and overflow flagging.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned DIGITS   = 4,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [BIN_W-1:0]    bin_in_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                ovf_o,
  output logic [4*DIGITS-1:0] bcd_out_o
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned SregW = BcdW + BIN_W;
  localparam int unsigned CntW  = $clog2(BIN_W + 1);

  localparam logic [BIN_W-1:0] MaxValW  = BIN_W'(max_val(DIGITS));
  localparam logic [CntW-1:0]  LastIter = CntW'(BIN_W - 1);

  state_e           state_q;
  logic [SregW-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q;
  logic             ovf_pend_q, busy_q, done_q, ovf_q;
  logic [BcdW-1:0]  bcd_q, adj, res, blanked;
  logic             lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .d_i(sreg_q[BIN_W + 4*g +: 4]),
      .d_o(adj[4*g +: 4])
    );
  end

  always_comb begin
    sreg_d = {adj, sreg_q[BIN_W-1:0]} << 1;
    res    = sreg_d[SregW-1 -: BcdW];
  end

  // Blank zero digits from the top down until the first nonzero; units digit always shown.
  always_comb begin
    blanked = res;
    lead    = 1'b1;
    if (BLANK_LZ) begin
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (lead && res[4*i +: 4] == 4'd0) begin
          blanked[4*i +: 4] = BLANK_NIBBLE;
        end else begin
          lead = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sreg_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sreg_q     <= {{BcdW{1'b0}}, bin_in_i};
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            ovf_pend_q <= bin_in_i > MaxValW;
            state_q    <= StShift;
          end
        end
        StShift: begin
          sreg_q <= sreg_d;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == LastIter) begin
            bcd_q   <= ovf_pend_q ? '1 : blanked;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= ovf_pend_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ovf_o     = ovf_q;
  assign bcd_out_o = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: plain and leading-zero-blanking converters driven in parallel
// against an arithmetic decimal-digit reference.
module tb_bin2bcd_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy, done, ovf, busy_z, done_z, ovf_z;
  logic [15:0] bcd, bcd_z;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  bin2bcd_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bin_in_i(bin_in),
    .busy_o(busy), .done_o(done), .ovf_o(ovf), .bcd_out_o(bcd)
  );

  bin2bcd_seq #(.BLANK_LZ(1'b1)) u_dut_lz (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bin_in_i(bin_in),
    .busy_o(busy_z), .done_o(done_z), .ovf_o(ovf_z), .bcd_out_o(bcd_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by division; a digit is a leading zero iff v < 10^i.
  function automatic logic [15:0] ref_bcd(input int v, input bit blank);
    logic [15:0] r;
    int p;
    if (v > 9999) return 16'hFFFF;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      if (blank && i > 0 && v < p) r[4*i +: 4] = 4'hF;
      p = p * 10;
    end
    return r;
  endfunction

  // Called just after a clock edge with the converters idle (or in their done cycle).
  task automatic launch(input int v);
    start  = 1'b1;
    bin_in = 14'(v);
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = 14'($urandom_range(0, 16383));
  endtask

  task automatic finish_conv(input int v, input string tag, input int poke_at);
    int n;
    int ndone;
    bit steady;
    logic [15:0] held, held_z;
    logic held_ovf;
    held     = bcd;
    held_z   = bcd_z;
    held_ovf = ovf;
    steady   = 1'b1;
    ndone    = 0;
    n        = 0;
    check($sformatf("%s busy_after_accept", tag), {31'd0, busy}, 32'd1);
    while (n < 30) begin
      if (n == poke_at) begin
        start  = 1'b1;
        bin_in = 14'd7777;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done === 1'b1) break;
      if (busy !== 1'b1 || busy_z !== 1'b1 || done_z !== 1'b0 || bcd !== held ||
          bcd_z !== held_z || ovf !== held_ovf) steady = 1'b0;
    end
    check($sformatf("%s latency", tag), n, 14);
    check($sformatf("%s steady_while_busy", tag), {31'd0, steady}, 32'd1);
    check($sformatf("%s done_lz", tag), {31'd0, done_z}, 32'd1);
    check($sformatf("%s busy_at_done", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s bcd", tag), {16'd0, bcd}, {16'd0, ref_bcd(v, 1'b0)});
    check($sformatf("%s bcd_lz", tag), {16'd0, bcd_z}, {16'd0, ref_bcd(v, 1'b1)});
    check($sformatf("%s ovf", tag), {31'd0, ovf}, {31'd0, v > 9999});
    check($sformatf("%s ovf_lz", tag), {31'd0, ovf_z}, {31'd0, v > 9999});
  endtask

  // One idle cycle after done: pulse must drop, result must hold.
  task automatic idle_step(input int v, input string tag);
    @(posedge clk);
    #1;
    check($sformatf("%s done_dropped", tag), {30'd0, done, done_z}, 32'd0);
    check($sformatf("%s held", tag), {bcd_z, bcd}, {ref_bcd(v, 1'b1), ref_bcd(v, 1'b0)});
  endtask

  task automatic convert(input int v, input string tag);
    launch(v);
    finish_conv(v, tag, -1);
    idle_step(v, tag);
  endtask

  initial begin
    int v;
    int quiet;
    #2 rst_n = 1'b0;
    #1;
    check("reset outputs", {busy, done, ovf, bcd, busy_z, done_z, ovf_z, bcd_z}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    convert(1234, "d1234");
    convert(0, "d0");
    convert(9999, "d9999");
    convert(10000, "d10000");
    convert(16383, "d16383");
    convert(5, "d5");
    convert(42, "d42");
    convert(1005, "d1005");

    // start while busy is ignored; start in the done cycle is accepted
    launch(321);
    finish_conv(321, "d321_poke", 5);
    launch(88);
    check("chain done_dropped", {31'd0, done}, 32'd0);
    finish_conv(88, "d88_chain", -1);
    idle_step(88, "d88_chain");

    for (int i = 0; i < 24; i++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                      : int'($urandom_range(0, 9999));
      launch(v);
      finish_conv(v, $sformatf("rand%0d_%0d", i, v), -1);
      if (i % 2 == 0) idle_step(v, $sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of a conversion
    convert(16383, "pre_reset");
    launch(4321);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset outputs", {busy, done, ovf, bcd, busy_z, done_z, ovf_z, bcd_z}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0 || done_z !== 1'b0) quiet = 0;
    end
    check("no done after reset", quiet, 1);
    convert(77, "post_reset");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
